// File: rtl/ieee_adder_if.sv
// Operand/result handshake bundle for the pipelined IEEE-754 adder.
// The master drives operands and out_ready. The slave (the adder) returns in_ready, result and flags.
interface ieee_adder_if #(
    parameter int unsigned TOTALBITS = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 add_sub_bit;
    logic [TOTALBITS-1:0] numberA;
    logic [TOTALBITS-1:0] numberB;
    logic                 out_valid;
    logic                 out_ready;
    logic [TOTALBITS-1:0] outputC;
    logic [3:0]           flags;

    modport master (
        output in_valid, add_sub_bit, numberA, numberB, out_ready,
        input  in_ready, out_valid, outputC, flags
    );

    modport slave (
        input  in_valid, add_sub_bit, numberA, numberB, out_ready,
        output in_ready, out_valid, outputC, flags
    );
endinterface

// File: rtl/ieee_adder_pipelined.sv
// Parametrised IEEE-754 add/subtract with four stages: unpack, align, add, normalise/round.
// The whole pipe advances or holds as one unit. flags = {invalid, overflow, underflow, inexact}.
module ieee_adder_pipelined #(
    parameter int unsigned EXPO_LEN   = 8,
    parameter int unsigned SIGNIF_LEN = 23,
    parameter int unsigned GUARDBITS  = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    ieee_adder_if.slave    bus
);
    localparam int unsigned TOTALBITS = 1 + EXPO_LEN + SIGNIF_LEN;
    localparam int unsigned MW  = SIGNIF_LEN + 1;
    localparam int unsigned AW  = MW + GUARDBITS;
    localparam int unsigned SW  = AW + 1;
    localparam int unsigned EW  = EXPO_LEN + 1;
    localparam int unsigned LZW = $clog2(AW + 1);

    localparam logic [TOTALBITS-1:0] QNAN = {1'b0, {EXPO_LEN{1'b1}}, 1'b1, {(SIGNIF_LEN-1){1'b0}}};
    localparam logic [TOTALBITS-2:0] INF_BODY = {{EXPO_LEN{1'b1}}, {SIGNIF_LEN{1'b0}}};

    typedef struct packed {
        logic                 special;
        logic [TOTALBITS-1:0] sval;
        logic [3:0]           sflags;
        logic                 sign;
        logic                 eff_sub;
        logic [EXPO_LEN-1:0]  expo;
        logic [EXPO_LEN-1:0]  shift;
        logic [MW-1:0]        mbig;
        logic [MW-1:0]        msml;
    } s1_t;

    typedef struct packed {
        logic                 special;
        logic [TOTALBITS-1:0] sval;
        logic [3:0]           sflags;
        logic                 sign;
        logic                 eff_sub;
        logic [EXPO_LEN-1:0]  expo;
        logic [AW-1:0]        abig;
        logic [AW-1:0]        asml;
    } s2_t;

    typedef struct packed {
        logic                 special;
        logic [TOTALBITS-1:0] sval;
        logic [3:0]           sflags;
        logic                 sign;
        logic [EXPO_LEN-1:0]  expo;
        logic [SW-1:0]        sum;
    } s3_t;

    logic advance;
    logic v1, v2, v3;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    s3_t  s3_d, s3_q;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    // S1: unpack, order operands by magnitude, resolve NaN/inf
    logic                  sign_a, sign_b, nan_a, nan_b, inf_a, inf_b, a_big;
    logic [EXPO_LEN-1:0]   exp_a, exp_b, eff_a, eff_b;
    logic [SIGNIF_LEN-1:0] frac_a, frac_b;

    always_comb begin
        sign_a = bus.numberA[TOTALBITS-1];
        sign_b = bus.numberB[TOTALBITS-1] ^ bus.add_sub_bit;
        exp_a  = bus.numberA[TOTALBITS-2 -: EXPO_LEN];
        exp_b  = bus.numberB[TOTALBITS-2 -: EXPO_LEN];
        frac_a = bus.numberA[SIGNIF_LEN-1:0];
        frac_b = bus.numberB[SIGNIF_LEN-1:0];
        eff_a  = (exp_a == '0) ? EXPO_LEN'(1) : exp_a;
        eff_b  = (exp_b == '0) ? EXPO_LEN'(1) : exp_b;
        nan_a  = (&exp_a) && (|frac_a);
        nan_b  = (&exp_b) && (|frac_b);
        inf_a  = (&exp_a) && !(|frac_a);
        inf_b  = (&exp_b) && !(|frac_b);
        a_big  = {exp_a, frac_a} >= {exp_b, frac_b};

        s1_d         = '0;
        s1_d.eff_sub = sign_a ^ sign_b;
        if (a_big) begin
            s1_d.sign  = sign_a;
            s1_d.expo  = eff_a;
            s1_d.shift = eff_a - eff_b;
            s1_d.mbig  = {|exp_a, frac_a};
            s1_d.msml  = {|exp_b, frac_b};
        end else begin
            s1_d.sign  = sign_b;
            s1_d.expo  = eff_b;
            s1_d.shift = eff_b - eff_a;
            s1_d.mbig  = {|exp_b, frac_b};
            s1_d.msml  = {|exp_a, frac_a};
        end

        if (nan_a || nan_b) begin
            s1_d.special = 1'b1;
            s1_d.sval    = QNAN;
        end else if (inf_a && inf_b && s1_d.eff_sub) begin
            s1_d.special = 1'b1;
            s1_d.sval    = QNAN;
            s1_d.sflags  = 4'b1000;
        end else if (inf_a) begin
            s1_d.special = 1'b1;
            s1_d.sval    = {sign_a, INF_BODY};
        end else if (inf_b) begin
            s1_d.special = 1'b1;
            s1_d.sval    = {sign_b, INF_BODY};
        end
    end

    // S2: align the smaller significand; everything shifted out collapses into sticky
    logic [AW-1:0] sml_ext, lost_mask;

    always_comb begin
        s2_d         = '0;
        s2_d.special = s1_q.special;
        s2_d.sval    = s1_q.sval;
        s2_d.sflags  = s1_q.sflags;
        s2_d.sign    = s1_q.sign;
        s2_d.eff_sub = s1_q.eff_sub;
        s2_d.expo    = s1_q.expo;
        s2_d.abig    = {s1_q.mbig, {GUARDBITS{1'b0}}};
        sml_ext      = {s1_q.msml, {GUARDBITS{1'b0}}};
        lost_mask    = ~({AW{1'b1}} << s1_q.shift);
        if (32'(s1_q.shift) >= AW) begin
            s2_d.asml = AW'(|s1_q.msml);
        end else begin
            s2_d.asml    = sml_ext >> s1_q.shift;
            s2_d.asml[0] = s2_d.asml[0] | (|(sml_ext & lost_mask));
        end
    end

    // S3: magnitude add/subtract; big >= small so the difference never goes negative
    always_comb begin
        s3_d         = '0;
        s3_d.special = s2_q.special;
        s3_d.sval    = s2_q.sval;
        s3_d.sflags  = s2_q.sflags;
        s3_d.expo    = s2_q.expo;
        if (s2_q.eff_sub) s3_d.sum = {1'b0, s2_q.abig} - {1'b0, s2_q.asml};
        else              s3_d.sum = {1'b0, s2_q.abig} + {1'b0, s2_q.asml};
        s3_d.sign = (s2_q.eff_sub && (s3_d.sum == '0)) ? 1'b0 : s2_q.sign;
    end

    // S4: normalise, round to nearest even, pack
    logic [LZW-1:0]       lzc;
    logic [EW-1:0]        exp_n, lim, shamt;
    logic [AW-1:0]        norm;
    logic [MW:0]          mant_r;
    logic [EXPO_LEN-1:0]  exp_f;
    logic                 rnd_up, inexact, hidden;
    logic [TOTALBITS-1:0] res_d;
    logic [3:0]           flg_d;

    always_comb begin
        lzc = LZW'(AW);
        for (int i = 0; i < int'(AW); i++) begin
            if (s3_q.sum[i]) lzc = LZW'(int'(AW) - 1 - i);
        end
        exp_n = {1'b0, s3_q.expo};
        lim   = exp_n - EW'(1);
        shamt = '0;
        if (s3_q.sum[SW-1]) begin
            norm    = s3_q.sum[SW-1:1];
            norm[0] = norm[0] | s3_q.sum[0];
            exp_n   = exp_n + EW'(1);
        end else begin
            shamt = (EW'(lzc) < lim) ? EW'(lzc) : lim;
            norm  = s3_q.sum[AW-1:0] << shamt;
            exp_n = exp_n - shamt;
        end
        rnd_up  = norm[GUARDBITS-1] && ((|norm[GUARDBITS-2:0]) || norm[GUARDBITS]);
        inexact = |norm[GUARDBITS-1:0];
        mant_r  = {1'b0, norm[AW-1:GUARDBITS]} + {{MW{1'b0}}, rnd_up};
        if (mant_r[MW]) begin
            mant_r = mant_r >> 1;
            exp_n  = exp_n + EW'(1);
        end
        hidden = mant_r[MW-1];
        exp_f  = hidden ? exp_n[EXPO_LEN-1:0] : {EXPO_LEN{1'b0}};
        res_d  = {s3_q.sign, exp_f, mant_r[SIGNIF_LEN-1:0]};
        flg_d  = {2'b00, inexact && !hidden, inexact};
        if (exp_n >= EW'({EXPO_LEN{1'b1}})) begin
            res_d = {s3_q.sign, INF_BODY};
            flg_d = 4'b0101;
        end
        if (s3_q.special) begin
            res_d = s3_q.sval;
            flg_d = s3_q.sflags;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            v3            <= 1'b0;
            s1_q          <= '0;
            s2_q          <= '0;
            s3_q          <= '0;
            bus.out_valid <= 1'b0;
            bus.outputC   <= '0;
            bus.flags     <= '0;
        end else if (advance) begin
            v1            <= bus.in_valid;
            s1_q          <= s1_d;
            v2            <= v1;
            s2_q          <= s2_d;
            v3            <= v2;
            s3_q          <= s3_d;
            bus.out_valid <= v3;
            bus.outputC   <= res_d;
            bus.flags     <= flg_d;
        end
    end
endmodule
